// File: rtl/irq_request_latch.sv
// Request capture front end for the 4-line priority encoder: synchronises raw
// request lines, logs rising edges as sticky pending bits and presents the masked vector.
module irq_request_latch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic [3:0] mask_in,
    input  logic       clr_valid,
    input  logic [1:0] clr_idx,
    input  logic       ovf_clr,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic [3:0] pending,
    output logic [3:0] overflow,
    output logic       any_pending
);

    localparam int unsigned LINES = 4;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_depth
            $error("irq_request_latch: SYNC_STAGES must be 2 or more");
        end
    endgenerate

    logic [LINES-1:0] sync_q [SYNC_STAGES];
    logic [LINES-1:0] s;
    logic [LINES-1:0] p;
    logic [LINES-1:0] rise;
    logic [LINES-1:0] clr_hit;
    logic [LINES-1:0] pending_next;
    logic [LINES-1:0] overflow_next;
    logic [LINES-1:0] gated;

    // Synchroniser chain plus previous-value flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
            p <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            p <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p;

    // One-hot decode of the service clear strobe.
    always_comb begin
        clr_hit = '0;
        if (clr_valid) begin
            clr_hit[clr_idx] = 1'b1;
        end
    end

    // A new edge always beats a clear on the same line, and beats ovf_clr.
    always_comb begin
        pending_next  = pending;
        overflow_next = overflow;
        if (EDGE_MODE != 0) begin
            pending_next  = rise | (pending & ~clr_hit);
            overflow_next = (overflow & ~{LINES{ovf_clr}}) | (rise & pending & ~clr_hit);
        end else begin
            pending_next  = s;
            overflow_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    // Mask only gates what the encoder sees; latching continues underneath.
    assign gated       = pending & mask_in;
    assign d0          = gated[0];
    assign d1          = gated[1];
    assign d2          = gated[2];
    assign d3          = gated[3];
    assign any_pending = |gated;

endmodule
